// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the write side of the core's instruction memory. It takes
// a big-endian byte stream over a valid/ready handshake and packs every four
// bytes into one 32-bit word. The words are written to consecutive word-aligned
// byte addresses, starting at 0. The core is held (cpu_hold = 1) until the
// requested number of words has been written.
//
// Parameters
//   ADDR_W       byte-address width of the instruction memory (core PC width)
//   DEPTH_WORDS  memory capacity in words (2^ADDR_W / 4)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle load request, honoured only in IDLE or DONE
//   len_words  in   number of words to load, sampled with start
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data
//   in_ready   out  loader accepts a byte this cycle (RECV only)
//   mem_we     out  instruction-memory write enable, one cycle per word
//   mem_addr   out  byte address of the write (multiple of 4)
//   mem_wdata  out  assembled instruction word
//   cpu_hold   out  keep the core held; low only in DONE
//   busy       out  load in progress (RECV or WRITE)
//   done       out  last load completed
//   err        out  last start rejected for an oversize length (sticky)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W      = 5,
    parameter int DEPTH_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-2:0] len_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-2:0] MAX_LEN  = (ADDR_W-1)'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_INC = (ADDR_W)'(4);
    localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W-1)'(1);

    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [31:0]       wdata_reg,    wdata_next;
    logic [ADDR_W-2:0] word_cnt_reg, word_cnt_next;
    logic [ADDR_W-2:0] len_reg,      len_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic              err_reg,      err_next;

    // State register. Reset discards any partial word; memory contents
    // already written are outside this block and stay untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            word_cnt_reg <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            word_cnt_reg <= word_cnt_next;
            len_reg      <= len_next;
            byte_cnt_reg <= byte_cnt_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        word_cnt_next = word_cnt_reg;
        len_next      = len_reg;
        byte_cnt_next = byte_cnt_reg;
        err_next      = err_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (len_words == '0) begin
                        // Empty load: nothing to write, release the core.
                        err_next   = 1'b0;
                        state_next = ST_DONE;
                    end else if (len_words > MAX_LEN) begin
                        // Oversize request is refused so the address can
                        // never run past the end of memory.
                        err_next = 1'b1;
                    end else begin
                        len_next      = len_words;
                        word_cnt_next = '0;
                        byte_cnt_next = '0;
                        addr_next     = '0;
                        err_next      = 1'b0;
                        state_next    = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                if (in_valid) begin
                    // Big-endian: the first byte shifts up into bits 31:24.
                    wdata_next    = {wdata_reg[23:0], in_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                addr_next     = addr_reg + ADDR_INC;
                word_cnt_next = word_cnt_reg + CNT_ONE;
                if ((word_cnt_reg + CNT_ONE) == len_reg) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RECV;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign in_ready  = (state_reg == ST_RECV);
    assign mem_we    = (state_reg == ST_WRITE);
    assign busy      = (state_reg == ST_RECV) || (state_reg == ST_WRITE);
    assign done      = (state_reg == ST_DONE);
    assign cpu_hold  = (state_reg != ST_DONE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Expected memory writes are queued when a
// word is offered and popped by a monitor whenever mem_we is seen. Outputs are
// sampled on the falling edge; inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W      = 5;
    localparam int DEPTH_WORDS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-2:0] len_words;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int tests    = 0;
    int fails    = 0;
    int n_writes = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_words (len_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest queued word.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            n_writes++;
            if (exp_data_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("wr_data", mem_wdata, exp_data_q.pop_front());
            end
            $display("[TB] write addr=%0d data=%08h", mem_addr, mem_wdata);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the byte
    // has transferred. in_valid stays high so bytes can go back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(w);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[31-8*b -: 8]);
        end
        $display("[TB] sent word addr=%0d data=%08h", a, w);
    endtask

    task automatic do_start(input logic [ADDR_W-2:0] len);
        start     = 1'b1;
        len_words = len;
        @(negedge clk);
        start     = 1'b0;
        $display("[TB] start len_words=%0d", len);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] w;
        int          wr_base;

        rst       = 1'b0;
        start     = 1'b0;
        len_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;

        // Reset state before any clock edge.
        #2;
        check_reset_outputs("reset0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Oversize length: rejected, stays in IDLE with the core held.
        do_start(4'd9);
        check("len9_err",      32'(err),      32'd1);
        check("len9_cpu_hold", 32'(cpu_hold), 32'd1);
        check("len9_busy",     32'(busy),     32'd0);
        check("len9_done",     32'(done),     32'd0);
        check("len9_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("len9_err_sticky", 32'(err), 32'd1);

        // Zero length: straight to DONE, err cleared, no writes.
        do_start(4'd0);
        check("len0_done",     32'(done),     32'd1);
        check("len0_err",      32'(err),      32'd0);
        check("len0_cpu_hold", 32'(cpu_hold), 32'd0);
        check("len0_busy",     32'(busy),     32'd0);
        @(negedge clk);
        check("len0_no_write", 32'(n_writes), 32'd0);

        // Single word. RECV one cycle after start; write 5 cycles after start.
        do_start(4'd1);
        check("sw_in_ready", 32'(in_ready), 32'd1);
        check("sw_busy",     32'(busy),     32'd1);
        check("sw_cpu_hold", 32'(cpu_hold), 32'd1);
        check("sw_done",     32'(done),     32'd0);
        send_word(5'd0, 32'h20110005);
        in_valid = 1'b0;
        check("sw_we_pulse",   32'(mem_we),   32'd1);
        check("sw_write_rdy",  32'(in_ready), 32'd0);
        @(negedge clk);
        check("sw_done_next",  32'(done),     32'd1);
        check("sw_hold_fall",  32'(cpu_hold), 32'd0);
        check("sw_we_single",  32'(mem_we),   32'd0);
        check("sw_writes",     32'(n_writes), 32'd1);

        // Full 8-word load with 3-cycle stalls inside words 2 and 6.
        do_start(4'd8);
        for (int wi = 0; wi < 8; wi++) begin
            w = 32'hC0DE0000 | (32'(wi) << 8) | (32'(wi) * 32'h11);
            exp_addr_q.push_back(ADDR_W'(wi * 4));
            exp_data_q.push_back(w);
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8]);
                if ((wi == 2 || wi == 6) && b == 1) begin
                    in_valid = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        check("stall_we",    32'(mem_we),   32'd0);
                        check("stall_ready", 32'(in_ready), 32'd1);
                    end
                end
            end
            $display("[TB] sent word addr=%0d data=%08h", wi * 4, w);
        end
        in_valid = 1'b0;
        wait_done();
        check("full_writes", 32'(n_writes), 32'd9);
        check("full_sb_empty", 32'(exp_data_q.size()), 32'd0);

        // Reload from DONE with a start pulse ignored during RECV.
        wr_base = n_writes;
        do_start(4'd2);
        check("rl_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rl_done",     32'(done),     32'd0);
        exp_addr_q.push_back(5'd0);
        exp_data_q.push_back(32'h01234567);
        exp_addr_q.push_back(5'd4);
        exp_data_q.push_back(32'h89ABCDEF);
        send_byte(8'h01);
        in_valid  = 1'b0;
        start     = 1'b1;
        len_words = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy",     32'(busy),     32'd1);
        check("ign_in_ready", 32'(in_ready), 32'd1);
        check("ign_addr",     32'(mem_addr), 32'd0);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h67);
        send_byte(8'h89);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        in_valid = 1'b0;
        wait_done();
        check("rl_writes", 32'(n_writes - wr_base), 32'd2);

        // Reset mid-load after 2 bytes of word 3.
        do_start(4'd8);
        send_word(5'd0,  32'h11111111);
        send_word(5'd4,  32'h22222222);
        send_word(5'd8,  32'h33333333);
        send_byte(8'hDE);
        send_byte(8'hAD);
        in_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_sb_empty", 32'(exp_data_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_base = n_writes;
        do_start(4'd1);
        send_word(5'd0, 32'h13579BDF);
        in_valid = 1'b0;
        wait_done();
        check("post_rst_writes", 32'(n_writes - wr_base), 32'd1);
        check("post_rst_wdata",  mem_wdata, 32'h13579BDF);
        check("total_writes",    32'(n_writes), 32'd15);
        check("final_sb_empty",  32'(exp_data_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader on the write side of the single-cycle core's instruction memory. Accepts a big-endian byte stream over a valid/ready handshake, packs each group of four bytes into a 32-bit instruction word, and writes the words to consecutive word-aligned byte addresses starting at 0. Holds the core in reset (`cpu_hold`) until the requested number of words has been written, then releases it.

## Interface
- `ADDR_W`, 5: width of the instruction-memory byte address. Matches the core PC width.
- `DEPTH_WORDS`, 8: instruction-memory capacity in words, equal to 2^ADDR_W / 4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- `len_words`  in  ADDR_W-1  number of words to load; sampled with `start`.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_W  byte address of the write; always a multiple of 4.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  1 = keep the core in reset or stalled.
- `busy`  out  1  load in progress (RECV or WRITE).
- `done`  out  1  last load completed; held until the next accepted `start`.
- `err`  out  1  the last `start` was rejected because `len_words` > DEPTH_WORDS. Sticky until the next accepted `start`.

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - `start` with 0 < `len_words` ≤ DEPTH_WORDS: latch the length, clear the word counter, byte counter, `mem_addr` and `err`, then go to RECV.
  - `start` with `len_words` = 0: go directly to DONE. No writes occur.
  - `start` with `len_words` > DEPTH_WORDS: set `err`, stay in IDLE.
- RECV:
  - `in_ready` = 1.
  - On each cycle with `in_valid` && `in_ready`: shift `mem_wdata` <= {`mem_wdata`[23:0], `in_data`} and increment the 2-bit byte counter. The first byte of a word ends up in bits 31:24.
  - When the 4th byte is accepted, go to WRITE.
  - While `in_valid` = 0, hold all state.
- WRITE:
  - `mem_we` = 1 for exactly this one cycle. `mem_addr` and `mem_wdata` are stable.
  - `in_ready` = 0.
  - On exit: `mem_addr` += 4, word counter += 1.
  - If the word counter now equals `len_words`, go to DONE; otherwise go to RECV.
- DONE:
  - `done` = 1, `cpu_hold` = 0, `in_ready` = 0.
  - `start` re-runs the IDLE acceptance rules: a valid length goes to RECV with `cpu_hold` = 1 and `done` = 0.
- `cpu_hold` = 1 in IDLE, RECV and WRITE; 0 only in DONE.
- `busy` = 1 in RECV and WRITE.
- `start` in RECV or WRITE is ignored.
- Bytes offered outside RECV are not consumed, because `in_ready` = 0.
- Address never wraps: the maximum final `mem_addr` is 4·(DEPTH_WORDS−1), guaranteed by the length check.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - state IDLE
  - `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
  - `cpu_hold` 1, `busy` 0, `done` 0, `err` 0
- Reset mid-load: the partial word is discarded and the next load restarts at address 0. Words already written to memory are not touched.
- Latency from `start` to RECV: 1 cycle.
- With `in_valid` held high, each word costs 5 cycles (4 RECV + 1 WRITE).
- The first `mem_we` occurs 5 cycles after the `start` cycle.
- DONE is entered 1 cycle after the last WRITE. `cpu_hold` falls in that same cycle.
- A full 8-word load with no stalls takes 40 cycles from RECV entry to DONE.
- Handshake: a byte transfers only on a rising edge where `in_valid` && `in_ready`. The source may drop `in_valid` at any time.

## Test plan
- **Reset:** drive `rst` = 0 asynchronously mid-cycle → all outputs take their reset values immediately, with no clock edge needed.
- **Single word:** `start`, `len_words` = 1, bytes 0x20,0x11,0x00,0x05 back-to-back → one `mem_we` pulse with `mem_addr` = 0 and `mem_wdata` = 0x20110005; DONE one cycle later; `cpu_hold` falls.
- **Full load with stalls:** `len_words` = 8, `in_valid` deasserted for 3 cycles inside words 2 and 6 → 8 writes at addresses 0,4,…,28 with correct words; `mem_we` never asserted during a stall.
- **Length limits:**
  - `start` with `len_words` = 9 → `err` = 1, state stays IDLE, no writes, `cpu_hold` = 1.
  - Then `start` with `len_words` = 0 → DONE, `err` = 0, no writes.
- **Ignored start / reload:** pulse `start` during RECV → no effect. After DONE, `start` with `len_words` = 2 → `cpu_hold` = 1 and `done` = 0 again; writes restart at address 0.
- **Reset mid-load:** apply reset after 2 bytes of word 3 → IDLE; the next load writes word 0 at address 0, and no stale bytes appear in `mem_wdata`'s assembled word.
